// File: rtl/seg_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// seg_pkg : glyph table, blank codes and one-hot helper for seg_scan_driver
// Rev 1.0
// ----------------------------------------------------------------
package seg_pkg;

  // Index is the nibble value; bits 6:0 = g f e d c b a
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DP    = 8'h80;

  localparam int unsigned MAX_DIGITS = 32;

  function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx);
    return MAX_DIGITS'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_glyph_enc.sv
`default_nettype none
// ----------------------------------------------------------------
// seg_glyph_enc : nibble + DP to 8-bit segment code with blanking priority
// Rev 1.0
// ----------------------------------------------------------------
module seg_glyph_enc (
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       enable,
  input  logic       blank_blink,
  input  logic       blank_lz,
  output logic [7:0] seg
);
  import seg_pkg::*;

  always_comb begin
    seg = SEG_BLANK;
    if (!enable || blank_blink) begin
      seg = SEG_BLANK;
    end else if (blank_lz) begin
      // A suppressed leading zero still carries its decimal point
      seg = dp ? SEG_DP : SEG_BLANK;
    end else begin
      seg = {dp, GLYPH[nibble]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ----------------------------------------------------------------
// seg_scan_driver : multiplexed 7-segment scanner with blink and zero blanking
// Rev 1.0
// ----------------------------------------------------------------
module seg_scan_driver #(
  parameter int GROUPS    = 2,
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [4*GROUPS*DIGITS-1:0]   value,
  input  logic [GROUPS*DIGITS-1:0]     dp,
  input  logic                         load,
  input  logic [GROUPS*DIGITS-1:0]     digit_en,
  input  logic [GROUPS*DIGITS-1:0]     blink,
  input  logic [GROUPS-1:0]            lz_blank,
  output logic [8*GROUPS-1:0]          seg,
  output logic [DIGITS*GROUPS-1:0]     seg_sel
);
  import seg_pkg::*;

  localparam int DIV_W = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int IDX_W = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [4*GROUPS*DIGITS-1:0] buf_val_q, buf_val_d;
  logic [GROUPS*DIGITS-1:0]   buf_dp_q,  buf_dp_d;
  logic [DIV_W-1:0]           div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]           idx_q,     idx_d;
  logic [BLK_W-1:0]           blink_cnt_q, blink_cnt_d;
  logic                       blink_phase_q, blink_phase_d;
  logic [8*GROUPS-1:0]        seg_q,     seg_d;
  logic [DIGITS*GROUPS-1:0]   seg_sel_q, seg_sel_d;

  logic              tick;
  logic              round_end;
  logic [DIGITS-1:0] sel_onehot;

  always_comb begin
    buf_val_d = buf_val_q;
    buf_dp_d  = buf_dp_q;
    if (load) begin
      buf_val_d = value;
      buf_dp_d  = dp;
    end

    tick      = (div_cnt_q == DIV_LAST);
    round_end = tick && (idx_q == IDX_LAST);

    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);

    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (round_end) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  assign sel_onehot = DIGITS'(onehot(32'(idx_q)));

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    localparam int BASE = g * DIGITS;

    logic [3:0]        nib_arr [DIGITS];
    logic [DIGITS-1:0] zero_from;
    logic [DIGITS-1:0] dp_vec;
    logic [DIGITS-1:0] en_vec;
    logic [DIGITS-1:0] blink_vec;
    logic              run;
    logic              en_bit;
    logic              lz_bit;
    logic [7:0]        code;

    // zero_from[d]: every buffered nibble at positions d..DIGITS-1 is zero
    always_comb begin
      run       = 1'b1;
      zero_from = '0;
      for (int d = DIGITS - 1; d >= 0; d--) begin
        nib_arr[d]   = buf_val_q[(BASE + d)*4 +: 4];
        run          = run && (nib_arr[d] == 4'h0);
        zero_from[d] = run;
      end
    end

    assign dp_vec    = buf_dp_q[BASE +: DIGITS];
    assign en_vec    = digit_en[BASE +: DIGITS];
    assign blink_vec = blink[BASE +: DIGITS];
    assign en_bit    = en_vec[idx_q];
    assign lz_bit    = lz_blank[g] && (idx_q != '0) && zero_from[idx_q];

    seg_glyph_enc u_enc (
      .nibble      (nib_arr[idx_q]),
      .dp          (dp_vec[idx_q]),
      .enable      (en_bit),
      .blank_blink (blink_vec[idx_q] && blink_phase_q),
      .blank_lz    (lz_bit),
      .seg         (code)
    );

    assign seg_d[g*8 +: 8]              = code;
    assign seg_sel_d[g*DIGITS +: DIGITS] = en_bit ? sel_onehot : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_val_q     <= '0;
      buf_dp_q      <= '0;
      div_cnt_q     <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      seg_q         <= '0;
      seg_sel_q     <= '0;
    end else begin
      buf_val_q     <= buf_val_d;
      buf_dp_q      <= buf_dp_d;
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_q         <= seg_d;
      seg_sel_q     <= seg_sel_d;
    end
  end

  assign seg     = seg_q;
  assign seg_sel = seg_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ----------------------------------------------------------------
// tb_seg_scan_driver : scoreboard bench with a cycle-count reference model
// Rev 1.0
// ----------------------------------------------------------------
module tb_seg_scan_driver;
  localparam int GROUPS    = 2;
  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;
  localparam int NB        = GROUPS * DIGITS;

  localparam logic [6:0] GL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic                 clk      = 1'b0;
  logic                 rst_n    = 1'b0;
  logic [4*NB-1:0]      value    = '0;
  logic [NB-1:0]        dp       = '0;
  logic                 load     = 1'b0;
  logic [NB-1:0]        digit_en = '1;
  logic [NB-1:0]        blink    = '0;
  logic [GROUPS-1:0]    lz_blank = '0;
  logic [8*GROUPS-1:0]  seg;
  logic [DIGITS*GROUPS-1:0] seg_sel;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .GROUPS    (GROUPS),
    .DIGITS    (DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .dp       (dp),
    .load     (load),
    .digit_en (digit_en),
    .blink    (blink),
    .lz_blank (lz_blank),
    .seg      (seg),
    .seg_sel  (seg_sel)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: scan position and blink phase derived purely from edges since reset
  logic [4*NB-1:0] m_val = '0;
  logic [NB-1:0]   m_dp  = '0;
  int              m_cnt = 0;
  logic [31:0]     sb [$];

  function automatic logic [31:0] expect_out();
    logic [15:0] s;
    logic [7:0]  sel;
    logic [7:0]  code;
    int          i, ph, k;
    bit          lz;
    s   = '0;
    sel = '0;
    i   = (m_cnt / SCAN_DIV) % DIGITS;
    ph  = (m_cnt / (SCAN_DIV * DIGITS * BLINK_DIV)) % 2;
    for (int g = 0; g < GROUPS; g++) begin
      k = g * DIGITS + i;
      if (digit_en[k]) begin
        sel[k] = 1'b1;
        lz = (lz_blank[g] == 1'b1) && (i > 0);
        for (int d = i; d < DIGITS; d++) begin
          if (m_val[(g*DIGITS + d)*4 +: 4] != 4'h0) lz = 1'b0;
        end
        if (blink[k] && ph == 1)  code = 8'h00;
        else if (lz)              code = {m_dp[k], 7'h00};
        else                      code = {m_dp[k], GL[m_val[k*4 +: 4]]};
        s[g*8 +: 8] = code;
      end
    end
    return {8'h00, s, sel};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_val = '0;
      m_dp  = '0;
      m_cnt = 0;
      sb.delete();
    end else begin
      sb.push_back(expect_out());
      if (load) begin
        m_val = value;
        m_dp  = dp;
      end
      m_cnt++;
      #1;
      if (sb.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
      else                chk("scan", {8'h00, seg, seg_sel}, sb.pop_front());
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_pulse(input logic [4*NB-1:0] v, input logic [NB-1:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    int guard;
    repeat (2) @(negedge clk);
    chk("reset_out", {8'h00, seg, seg_sel}, 32'h0);
    rst_n = 1'b1;
    run(20);

    load_pulse(32'hFEDC_BA98, 8'b1000_0001);
    run(20);

    lz_blank = 2'b01;
    load_pulse(32'h0000_0005, 8'h00);
    run(16);
    load_pulse(32'h0000_0000, 8'h00);
    run(16);
    lz_blank = 2'b00;

    load_pulse(32'h1234_5678, 8'h00);
    digit_en = 8'hFE;
    blink    = 8'h02;
    run(80);
    digit_en = '1;
    blink    = '0;

    load = 1'b1;
    repeat (12) begin
      @(negedge clk);
      value = $urandom;
      dp    = NB'($urandom);
    end
    @(negedge clk);
    load = 1'b0;
    run(4);

    // Load landing on the same edge as a digit advance
    guard = 0;
    while ((m_cnt % SCAN_DIV) != SCAN_DIV - 1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    chk("collision_align", 32'(m_cnt % SCAN_DIV), 32'(SCAN_DIV - 1));
    load_pulse(32'hA5A5_5A5A, 8'h3C);
    run(8);

    // Asynchronous reset in the middle of idx=2 dwell
    guard = 0;
    while ((m_cnt % (SCAN_DIV*DIGITS)) != 2*SCAN_DIV + 1 && guard < 32) begin
      @(negedge clk);
      guard++;
    end
    chk("midscan_align", 32'(m_cnt % (SCAN_DIV*DIGITS)), 32'(2*SCAN_DIV + 1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_seg", 32'(seg), 32'h0);
    chk("async_rst_sel", 32'(seg_sel), 32'h0);
    run(2);
    rst_n = 1'b1;
    run(20);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
